// File: rtl/comparador_operand_loader.sv
// comparador_operand_loader
// Bit-serial front end for the equal/different comparator. Two operands
// arrive MSB first (A, then B), are held on op_a/op_b with the captured mode
// on sel_out, the comparator result is registered once and handed downstream.
//
// Optional build macro: COMPARADOR_LOADER_MATCH_COUNT_EN
//   adds match_count[7:0] (saturating count of transferred results equal to 1)
//   and count_clr (synchronous clear, wins over an increment).
//
// Output handshake: res_out is valid while res_valid=1; a transfer happens on
// every rising edge where res_valid=1 and res_ready=1 (and abort=0). Once
// raised, res_valid and res_out stay unchanged until that transfer or an abort.
module comparador_operand_loader #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel_in,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             abort,
  input  logic             res_in,
  input  logic             res_ready,
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
  input  logic             count_clr,
  output logic [7:0]       match_count,
`endif
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             sel_out,
  output logic             res_out,
  output logic             res_valid,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_bit;
  logic             do_abort;
  logic             do_start;
  logic             shift_a;
  logic             shift_b;
  logic             xfer;

  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // Next-state logic and per-cycle strobes; abort outranks every other input.
  always_comb begin
    state_d  = state_q;
    do_abort = 1'b0;
    do_start = 1'b0;
    shift_a  = 1'b0;
    shift_b  = 1'b0;
    xfer     = 1'b0;
    if (state_q != IDLE && abort) begin
      do_abort = 1'b1;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            do_start = 1'b1;
            state_d  = LOAD_A;
          end
        end
        LOAD_A: begin
          if (bit_valid) begin
            shift_a = 1'b1;
            if (last_bit) state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (bit_valid) begin
            shift_b = 1'b1;
            if (last_bit) state_d = COMPARE;
          end
        end
        COMPARE: state_d = DONE;
        DONE: begin
          if (res_ready) begin
            xfer    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bit counter: counts accepted bits of the operand currently loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (do_abort || do_start) begin
      cnt_q <= '0;
    end else if (shift_a || shift_b) begin
      cnt_q <= last_bit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Operand and mode registers: cleared on start, shifted MSB first, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      sel_out <= 1'b0;
    end else if (do_start) begin
      op_a    <= '0;
      op_b    <= '0;
      sel_out <= sel_in;
    end else if (shift_a) begin
      op_a <= {op_a[WIDTH-2:0], bit_in};
    end else if (shift_b) begin
      op_b <= {op_b[WIDTH-2:0], bit_in};
    end
  end

  // Result register: sampled once in COMPARE, held until transfer or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_out   <= 1'b0;
      res_valid <= 1'b0;
    end else if (do_abort || xfer) begin
      res_valid <= 1'b0;
    end else if (state_q == COMPARE) begin
      res_out   <= res_in;
      res_valid <= 1'b1;
    end
  end

`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
  // Saturating count of transferred results equal to 1; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_count <= 8'd0;
    end else if (count_clr) begin
      match_count <= 8'd0;
    end else if (xfer && res_out && match_count != 8'hff) begin
      match_count <= match_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_comparador_operand_loader.sv
// Bench for comparador_operand_loader: directed cases plus randomized
// transactions, scored against a transaction-level model of the loader.
module tb_comparador_operand_loader;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sel_in;
  logic         bit_in;
  logic         bit_valid;
  logic         abort;
  logic         res_in;
  logic         res_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sel_out;
  logic         res_out;
  logic         res_valid;
  logic         busy;
  logic [2:0]   state_dbg;
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
  logic         count_clr;
  logic [7:0]   match_count;
  int           exp_count;
`endif

  int           n_vec;
  int           n_err;
  logic [0:0]   exp_q[$];

  comparador_operand_loader #(.WIDTH(W), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sel_in      (sel_in),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .abort       (abort),
    .res_in      (res_in),
    .res_ready   (res_ready),
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
    .count_clr   (count_clr),
    .match_count (match_count),
`endif
    .op_a        (op_a),
    .op_b        (op_b),
    .sel_out     (sel_out),
    .res_out     (res_out),
    .res_valid   (res_valid),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Attached combinational comparator: equality (sel=0) or difference (sel=1).
  assign res_in = sel_out ? (op_a != op_b) : (op_a == op_b);

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shift one operand in MSB first, with gap_min..gap_max idle cycles before each bit.
  task automatic send_operand(input logic [W-1:0] v, input int gap_min, input int gap_max);
    for (int i = W - 1; i >= 0; i--) begin
      int gaps;
      gaps = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gaps; g++) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(1, 0));
        @(negedge clk);
        check("gap_busy", 8'(busy), 8'd1);
        check("gap_valid", 8'(res_valid), 8'd0);
      end
      bit_valid = 1'b1;
      bit_in    = v[i];
      @(negedge clk);
      bit_valid = 1'b0;
    end
  endtask

  // One full load/compare/handshake transaction; ready_delay cycles of
  // back-pressure after res_valid rises.
  task automatic run_txn(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap_min, input int gap_max, input int ready_delay);
    logic [0:0] exp_res;
    logic [0:0] got_res;
    exp_res = sel ? 1'(a != b) : 1'(a == b);
    exp_q.push_back(exp_res);
    res_ready = (ready_delay == 0);
    start  = 1'b1;
    sel_in = sel;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 8'(busy), 8'd1);
    check("start_sel", 8'(sel_out), 8'(sel));
    check("start_op_a", 8'(op_a), 8'd0);
    check("start_op_b", 8'(op_b), 8'd0);
    send_operand(a, gap_min, gap_max);
    check("op_a_loaded", 8'(op_a), 8'(a));
    check("op_b_idle", 8'(op_b), 8'd0);
    send_operand(b, gap_min, gap_max);
    check("op_b_loaded", 8'(op_b), 8'(b));
    check("cmp_valid_low", 8'(res_valid), 8'd0);
    @(negedge clk);
    check("res_valid_rise", 8'(res_valid), 8'd1);
    for (int i = 0; i < ready_delay; i++) begin
      start = 1'($urandom_range(1, 0));
      @(negedge clk);
      check("hold_valid", 8'(res_valid), 8'd1);
      check("hold_op_a", 8'(op_a), 8'(a));
      check("hold_op_b", 8'(op_b), 8'(b));
      check("hold_sel", 8'(sel_out), 8'(sel));
    end
    start     = 1'b0;
    res_ready = 1'b1;
    got_res   = res_out;
    if (exp_q.size() > 0) begin
      check("res_out", 8'(got_res), 8'(exp_q.pop_front()));
    end else begin
      check("scoreboard_empty", 8'd1, 8'd0);
    end
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
    if (exp_res == 1'b1 && exp_count < 255) exp_count++;
`endif
    @(negedge clk);
    check("xfer_valid", 8'(res_valid), 8'd0);
    check("xfer_busy", 8'(busy), 8'd0);
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
    check("match_count", match_count, 8'(exp_count));
`endif
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    sel_in    = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b0;
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
    count_clr = 1'b0;
    exp_count = 0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op_a", 8'(op_a), 8'd0);
    check("rst_op_b", 8'(op_b), 8'd0);
    check("rst_sel", 8'(sel_out), 8'd0);
    check("rst_res_out", 8'(res_out), 8'd0);
    check("rst_res_valid", 8'(res_valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
    check("rst_count", match_count, 8'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_txn(1'b0, 3'b000, 3'b000, 0, 0, 0);
    run_txn(1'b1, 3'b001, 3'b010, 0, 0, 0);
    run_txn(1'b0, 3'b001, 3'b010, 0, 0, 5);
    run_txn(1'b1, 3'b101, 3'b101, 2, 2, 1);
    run_txn(1'b0, 3'b111, 3'b111, 0, 1, 2);

    // Abort after two bits of B; abort outranks a simultaneous bit_valid.
    start = 1'b1; sel_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_operand(3'b110, 0, 0);
    bit_valid = 1'b1; bit_in = 1'b1; @(negedge clk);
    bit_valid = 1'b1; bit_in = 1'b0; @(negedge clk);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; bit_valid = 1'b0;
    check("abort_busy", 8'(busy), 8'd0);
    check("abort_valid", 8'(res_valid), 8'd0);
    check("abort_op_a", 8'(op_a), 8'b110);
    check("abort_op_b", 8'(op_b), 8'b010);
    check("abort_sel", 8'(sel_out), 8'd1);
    run_txn(1'b0, 3'b011, 3'b011, 0, 1, 0);

    // Abort in IDLE does not block a start in the same cycle.
    abort = 1'b1; start = 1'b1; sel_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("idle_abort_start", 8'(busy), 8'd1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_load_a", 8'(busy), 8'd0);

    // Abort in DONE wins over res_ready: no transfer, no count.
    start = 1'b1; sel_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    send_operand(3'b010, 0, 0);
    send_operand(3'b010, 0, 0);
    @(negedge clk);
    check("done_valid", 8'(res_valid), 8'd1);
    check("done_res", 8'(res_out), 8'd1);
    abort = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("done_abort_valid", 8'(res_valid), 8'd0);
    check("done_abort_busy", 8'(busy), 8'd0);
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
    check("abort_count", match_count, 8'(exp_count));
`endif

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(1, 0)), W'($urandom_range(7, 0)), W'($urandom_range(7, 0)),
              0, 2, int'($urandom_range(3, 0)));
    end

`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
    // Clear wins; then three transfers with results 1,0,1.
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    exp_count = 0;
    check("count_clr", match_count, 8'd0);
    run_txn(1'b0, 3'b100, 3'b100, 0, 0, 0);
    run_txn(1'b0, 3'b100, 3'b101, 0, 0, 0);
    run_txn(1'b1, 3'b100, 3'b101, 0, 0, 0);
    check("count_three", match_count, 8'd2);
`endif

    // Reset mid LOAD_B clears everything without a clock edge.
    start = 1'b1; sel_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_operand(3'b111, 0, 0);
    bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_op_a", 8'(op_a), 8'd0);
    check("mid_rst_op_b", 8'(op_b), 8'd0);
    check("mid_rst_sel", 8'(sel_out), 8'd0);
    check("mid_rst_res_out", 8'(res_out), 8'd0);
    check("mid_rst_valid", 8'(res_valid), 8'd0);
    check("mid_rst_busy", 8'(busy), 8'd0);
`ifdef COMPARADOR_LOADER_MATCH_COUNT_EN
    check("mid_rst_count", match_count, 8'd0);
    exp_count = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 8'(res_valid), 8'd0);
    run_txn(1'b1, 3'b110, 3'b011, 0, 1, 1);

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/comparador_operand_loader.md
Name: comparador_operand_loader

Overview:
- Sequential front-end stage that feeds the 3-bit equal/different comparator.
- Receives two operands bit-serially (MSB first) plus a mode bit, holds them stable on the comparator inputs, samples the comparator's 1-bit result and hands it downstream with a valid/ready handshake.
- Sits between a serial source (switch/UART-style bit stream) and the combinational comparator.

Parameters:
- WIDTH, 3, operand width in bits; minimum 2.
- CNT_W, 2, width of the bit counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a load sequence; sampled only in IDLE
- sel_in  input  1  mode: 0 = equality, 1 = difference; captured with start
- bit_in  input  1  serial operand bit
- bit_valid  input  1  bit_in is valid this cycle
- abort  input  1  synchronous abort back to IDLE
- res_in  input  1  comparator result (combinational from op_a/op_b/sel_out)
- res_ready  input  1  downstream accepts res_out
- op_a  output  WIDTH  operand A to comparator
- op_b  output  WIDTH  operand B to comparator
- sel_out  output  1  mode to comparator
- res_out  output  1  registered comparator result
- res_valid  output  1  res_out valid
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - op_a, op_b, sel_out, res_out, res_valid and the counter all 0.
  - busy=0.
- States: IDLE, LOAD_A, LOAD_B, COMPARE, DONE. All registers update on the rising clk edge.
- IDLE:
  - start=1: sel_out<=sel_in, op_a<=0, op_b<=0, cnt<=0, go to LOAD_A.
  - bit_valid is ignored.
- LOAD_A:
  - On each bit_valid=1: op_a<={op_a[WIDTH-2:0],bit_in}, cnt++.
  - On the WIDTH-th bit: cnt<=0, go to LOAD_B.
  - bit_valid=0 stalls with no change.
- LOAD_B: same shift rule applied to op_b. On the WIDTH-th bit, go to COMPARE.
- COMPARE (exactly one cycle):
  - res_out<=res_in, res_valid<=1, go to DONE.
  - Operands have been stable for the full cycle, so no settle stage is needed.
- DONE:
  - res_valid=1; op_a, op_b, sel_out and res_out held.
  - res_ready=1: res_valid<=0, go to IDLE.
  - start in the same cycle is ignored; a new sequence needs start in IDLE.
- Latency: last B bit accepted at edge N; res_valid is high after edge N+1. With res_ready tied high, busy drops after edge N+2.
- Transfer occurs on an edge where res_valid=1 and res_ready=1.
- op_a, op_b and sel_out only change in IDLE (clear on start) and during LOAD_A/LOAD_B shifts.
- abort=1 in any state except IDLE:
  - Go to IDLE, res_valid<=0, cnt<=0.
  - op_a, op_b, sel_out keep their current values.
  - abort has priority over bit_valid and res_ready.
- abort in IDLE: no effect; start in the same cycle is honoured.
- start, bit_valid and res_ready in states where they are not listed are ignored.
- Reset asserted mid-sequence: immediate return to the reset values above; no partial result is ever flagged valid.

Optional Feature:
- Macro: COMPARADOR_LOADER_MATCH_COUNT_EN.
- Defined:
  - Adds output match_count[7:0], reset 0.
  - Increments on each handshake transfer where res_out=1; saturates at 255.
  - Adds input count_clr, a synchronous clear; clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset then start with sel_in=0; stream A=000, B=000; comparator attached, res_ready=1 -> res_out=1, res_valid pulses for one cycle, 2 cycles after the last bit.
- sel_in=1; A=001, B=010 -> op_a=001, op_b=010 held through DONE; res_out=1.
- sel_in=0; A=001, B=010; res_ready=0 for 5 cycles, then 1 -> res_valid held high for 6 cycles, res_out=0 stable, IDLE after the ready edge.
- bit_valid gaps: A=101 sent with 2 idle cycles between bits -> op_a=101; state stays LOAD_A until the 3rd valid bit.
- abort after 2 bits of B -> IDLE next edge, res_valid=0, busy=0. A new start restarts cleanly with op_a=op_b=000.
- rst_n low during LOAD_B -> all outputs 0 immediately, without waiting for a clock edge. With MATCH_COUNT_EN defined: three transfers with res_out=1,0,1 -> match_count=2.
